alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 118 +++++++++++
 tb/tb_alu_issue_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Execute-stage issue register: holds one decoded instruction, resolves operand
// forwarding from MEM/WB and stalls on a load-use hazard against the MEM stage.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  de_valid,
  output logic                  de_allowin,
  input  logic [4:0]            de_rs_num,
  input  logic [4:0]            de_rt_num,
  input  logic [DATA_WIDTH-1:0] de_rs_val,
  input  logic [DATA_WIDTH-1:0] de_rt_val,
  input  logic [DATA_WIDTH-1:0] de_imm,
  input  logic                  de_use_imm,
  input  logic [3:0]            de_aluop,
  input  logic [4:0]            de_dest,
  input  logic                  de_is_load,
  input  logic                  mem_valid,
  input  logic                  mem_is_load,
  input  logic [4:0]            mem_dest,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_result,
  input  logic                  mem_allowin,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [3:0]            alu_op,
  output logic                  ex_to_mem_valid,
  output logic [4:0]            ex_dest,
  output logic                  ex_is_load
);

  logic                  ex_valid_q, ex_valid_d;
  logic [4:0]            rs_num_q, rt_num_q, dest_q;
  logic [DATA_WIDTH-1:0] rs_val_q, rt_val_q, imm_q;
  logic                  use_imm_q, is_load_q;
  logic [3:0]            aluop_q;

  logic                  rs_hit, rt_hit, ready_go;
  logic [DATA_WIDTH-1:0] rs_fwd, rt_fwd;

  // rt only counts as a source when the immediate is not selected for B
  always_comb begin
    rs_hit   = (mem_dest == rs_num_q);
    rt_hit   = !use_imm_q && (mem_dest == rt_num_q);
    ready_go = !(ex_valid_q && mem_valid && mem_is_load &&
                 (mem_dest != '0) && (rs_hit || rt_hit));
  end

  always_comb begin
    rs_fwd = rs_val_q;
    if (rs_num_q != '0) begin
      if (mem_valid && !mem_is_load && (mem_dest == rs_num_q))
        rs_fwd = mem_result;
      else if (wb_valid && (wb_dest == rs_num_q))
        rs_fwd = wb_result;
    end
  end

  always_comb begin
    rt_fwd = rt_val_q;
    if (rt_num_q != '0) begin
      if (mem_valid && !mem_is_load && (mem_dest == rt_num_q))
        rt_fwd = mem_result;
      else if (wb_valid && (wb_dest == rt_num_q))
        rt_fwd = wb_result;
    end
  end

  always_comb begin
    de_allowin      = !ex_valid_q || (ready_go && mem_allowin);
    ex_to_mem_valid = ex_valid_q && ready_go && !flush;
    alu_A           = rs_fwd;
    alu_B           = use_imm_q ? imm_q : rt_fwd;
    alu_op          = aluop_q;
    ex_dest         = dest_q;
    ex_is_load      = is_load_q;
  end

  // flush wins over a same-cycle load; data fields may still load
  always_comb begin
    ex_valid_d = de_allowin ? de_valid : ex_valid_q;
    if (flush)
      ex_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_q <= 1'b0;
      rs_num_q   <= '0;
      rt_num_q   <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      aluop_q    <= '0;
      dest_q     <= '0;
      is_load_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (de_allowin) begin
        rs_num_q  <= de_rs_num;
        rt_num_q  <= de_rt_num;
        rs_val_q  <= de_rs_val;
        rt_val_q  <= de_rt_val;
        imm_q     <= de_imm;
        use_imm_q <= de_use_imm;
        aluop_q   <= de_aluop;
        dest_q    <= de_dest;
        is_load_q <= de_is_load;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized
// traffic compared against a transaction-level model of the held instruction.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        de_valid, de_allowin, de_use_imm, de_is_load;
  logic [4:0]  de_rs_num, de_rt_num, de_dest;
  logic [31:0] de_rs_val, de_rt_val, de_imm;
  logic [3:0]  de_aluop;
  logic        mem_valid, mem_is_load, wb_valid, mem_allowin, flush;
  logic [4:0]  mem_dest, wb_dest;
  logic [31:0] mem_result, wb_result;
  logic [31:0] alu_A, alu_B;
  logic [3:0]  alu_op;
  logic        ex_to_mem_valid, ex_is_load;
  logic [4:0]  ex_dest;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .de_valid(de_valid), .de_allowin(de_allowin),
    .de_rs_num(de_rs_num), .de_rt_num(de_rt_num),
    .de_rs_val(de_rs_val), .de_rt_val(de_rt_val),
    .de_imm(de_imm), .de_use_imm(de_use_imm), .de_aluop(de_aluop),
    .de_dest(de_dest), .de_is_load(de_is_load),
    .mem_valid(mem_valid), .mem_is_load(mem_is_load),
    .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result),
    .mem_allowin(mem_allowin), .flush(flush),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .ex_to_mem_valid(ex_to_mem_valid), .ex_dest(ex_dest), .ex_is_load(ex_is_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    int unsigned rs, rt, dest;
    int unsigned rsv, rtv, imm, op;
    bit          use_imm, ld;
  } instr_t;

  instr_t m;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned operand(input int unsigned num, input int unsigned stored);
    if (num == 0) return stored;
    if (mem_valid && !mem_is_load && mem_dest == num) return mem_result;
    if (wb_valid && wb_dest == num) return wb_result;
    return stored;
  endfunction

  function automatic bit load_use();
    if (!m.valid || !mem_valid || !mem_is_load || mem_dest == 0) return 0;
    return (mem_dest == m.rs) || (!m.use_imm && mem_dest == m.rt);
  endfunction

  function automatic bit exp_allowin();
    return !m.valid || (!load_use() && mem_allowin);
  endfunction

  task automatic check_all();
    chk_eq("allowin", 32'(de_allowin), 32'(exp_allowin()));
    chk_eq("out_valid", 32'(ex_to_mem_valid), 32'(m.valid && !load_use() && !flush));
    chk_eq("alu_A", alu_A, operand(m.rs, m.rsv));
    chk_eq("alu_B", alu_B, m.use_imm ? m.imm : operand(m.rt, m.rtv));
    chk_eq("alu_op", 32'(alu_op), m.op);
    chk_eq("ex_dest", 32'(ex_dest), m.dest);
    chk_eq("ex_is_load", 32'(ex_is_load), 32'(m.ld));
  endtask

  function automatic void model_clear();
    m = '{valid: 0, rs: 0, rt: 0, dest: 0, rsv: 0, rtv: 0, imm: 0, op: 0, use_imm: 0, ld: 0};
  endfunction

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic cycle();
    bit acc;
    @(negedge clk);
    check_all();
    acc = exp_allowin();
    @(posedge clk);
    if (!resetn) model_clear();
    else begin
      if (acc) begin
        m.rs = de_rs_num; m.rt = de_rt_num; m.rsv = de_rs_val; m.rtv = de_rt_val;
        m.imm = de_imm; m.use_imm = de_use_imm; m.op = de_aluop;
        m.dest = de_dest; m.ld = de_is_load; m.valid = de_valid;
      end
      if (flush) m.valid = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    de_valid = 0; de_rs_num = 0; de_rt_num = 0; de_rs_val = 0; de_rt_val = 0;
    de_imm = 0; de_use_imm = 0; de_aluop = 0; de_dest = 0; de_is_load = 0;
    mem_valid = 0; mem_is_load = 0; mem_dest = 0; mem_result = 0;
    wb_valid = 0; wb_dest = 0; wb_result = 0; mem_allowin = 1; flush = 0;
  endtask

  task automatic issue(input int unsigned rs, input int unsigned rsv, input int unsigned rt,
                       input int unsigned rtv, input bit ui, input int unsigned imm,
                       input int unsigned op);
    de_valid = 1; de_rs_num = 5'(rs); de_rs_val = rsv; de_rt_num = 5'(rt); de_rt_val = rtv;
    de_use_imm = ui; de_imm = imm; de_aluop = 4'(op); de_dest = 5'd10; de_is_load = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_valid"}, 32'(ex_to_mem_valid), 0);
    chk_eq({tag, "_allowin"}, 32'(de_allowin), 1);
    chk_eq({tag, "_A"}, alu_A, 0);
    chk_eq({tag, "_B"}, alu_B, 0);
    chk_eq({tag, "_op"}, 32'(alu_op), 0);
    chk_eq({tag, "_dest"}, 32'(ex_dest), 0);
  endtask

  initial begin
    idle_inputs();
    model_clear();
    resetn = 0;
    #3;
    check_reset_outputs("rst");
    cycle();
    cycle();
    resetn = 1;

    // plain issue
    issue(3, 5, 4, 7, 0, 0, 4'b0010);
    cycle();
    de_valid = 0;
    chk_eq("plain_A", alu_A, 5);
    chk_eq("plain_B", alu_B, 7);
    chk_eq("plain_op", 32'(alu_op), 4'b0010);
    chk_eq("plain_v", 32'(ex_to_mem_valid), 1);
    cycle();

    // forwarding priority
    issue(8, 0, 0, 0, 0, 0, 1);
    cycle();
    de_valid = 0; mem_allowin = 0;
    mem_valid = 1; mem_is_load = 0; mem_dest = 8; mem_result = 32'h11;
    wb_valid = 1; wb_dest = 8; wb_result = 32'h22;
    #1 chk_eq("fwd_mem", alu_A, 32'h11);
    mem_valid = 0;
    #1 chk_eq("fwd_wb", alu_A, 32'h22);
    cycle();
    idle_inputs();
    cycle();

    // load-use stall
    issue(9, 1, 0, 0, 0, 0, 3);
    cycle();
    issue(1, 2, 2, 3, 0, 0, 4);
    mem_valid = 1; mem_is_load = 1; mem_dest = 9;
    #1 chk_eq("lu_valid", 32'(ex_to_mem_valid), 0);
    chk_eq("lu_allowin", 32'(de_allowin), 0);
    cycle();
    chk_eq("lu_hold_op", 32'(alu_op), 3);
    mem_valid = 0; wb_valid = 1; wb_dest = 9; wb_result = 32'hABCD;
    #1 chk_eq("lu_fwd_A", alu_A, 32'hABCD);
    chk_eq("lu_go", 32'(ex_to_mem_valid), 1);
    cycle();
    idle_inputs();
    cycle();

    // zero register and immediate select
    issue(0, 0, 5, 9, 1, 32'hFFFF8000, 5);
    cycle();
    de_valid = 0;
    mem_valid = 1; mem_is_load = 0; mem_dest = 0; mem_result = 32'hFF;
    #1 chk_eq("zero_A", alu_A, 0);
    mem_is_load = 1; mem_dest = 5;
    #1 chk_eq("imm_B", alu_B, 32'hFFFF8000);
    chk_eq("imm_nostall", 32'(ex_to_mem_valid), 1);
    cycle();
    idle_inputs();

    // back-pressure, then flush with a new instruction offered
    issue(2, 20, 3, 30, 0, 0, 6);
    cycle();
    issue(4, 40, 5, 50, 0, 0, 7);
    mem_allowin = 0;
    cycle();
    chk_eq("bp_hold_A", alu_A, 20);
    mem_allowin = 1; flush = 1;
    #1 chk_eq("flush_now", 32'(ex_to_mem_valid), 0);
    cycle();
    flush = 0;
    #1 chk_eq("flush_next", 32'(ex_to_mem_valid), 0);
    cycle();

    // randomized traffic with occasional async reset
    for (int i = 0; i < 600; i++) begin
      de_valid = ($urandom_range(0, 3) != 0);
      de_rs_num = 5'($urandom_range(0, 3)); de_rt_num = 5'($urandom_range(0, 3));
      de_rs_val = $urandom; de_rt_val = $urandom; de_imm = $urandom;
      de_use_imm = 1'($urandom_range(0, 1)); de_aluop = 4'($urandom);
      de_dest = 5'($urandom); de_is_load = 1'($urandom_range(0, 1));
      mem_valid = 1'($urandom_range(0, 1)); mem_is_load = 1'($urandom_range(0, 1));
      mem_dest = 5'($urandom_range(0, 3)); mem_result = $urandom;
      wb_valid = 1'($urandom_range(0, 1)); wb_dest = 5'($urandom_range(0, 3));
      wb_result = $urandom;
      mem_allowin = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) begin
        #2 resetn = 0;
        model_clear();
        #1 chk_eq("arst_valid", 32'(ex_to_mem_valid), 0);
        idle_inputs();
        de_valid = 1;
        #1 check_reset_outputs("arst");
        cycle();
        resetn = 1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
